// File: rtl/cacheline_burst_adapter_if.sv
// Bus bundle for cacheline_burst_adapter.
// Cache side: line_i/line_o, address_i, read_i, write_i, resp_o.
// Memory side: burst_i/burst_o, address_o, read_o, write_o, resp_i.
// Modports:
//   slave  - the adapter. It receives the cache request and the memory beats.
//   master - the environment. It plays both the cache and the memory.
interface cacheline_burst_adapter_if #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 32
);
    // Cache side
    logic [LINE_WIDTH-1:0]  line_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic [ADDR_WIDTH-1:0]  address_i;
    logic                   read_i;
    logic                   write_i;
    logic                   resp_o;
    // Memory side
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [ADDR_WIDTH-1:0]  address_o;
    logic                   read_o;
    logic                   write_o;
    logic                   resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Converts one cache line read or write into a burst of BEATS memory beats.
// The cache side uses a level request held until a one-cycle resp_o pulse.
// The memory side strobes resp_i once for each beat it accepts or returns.
// Ports:
//   clk  - clock; all state changes on the rising edge.
//   rst  - synchronous, active-high reset.
//   bus  - cacheline_burst_adapter_if.slave.
//          line_i, address_i, read_i and write_i come from the cache.
//          line_o and resp_o go back to the cache.
//          burst_o, address_o, read_o and write_o go to memory.
//          burst_i and resp_i come back from memory.
module cacheline_burst_adapter #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input logic                      clk,
    input logic                      rst,
    cacheline_burst_adapter_if.slave bus
);

    localparam int unsigned BEATS  = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_t;

    state_t                            state_q, state_d;
    logic [BEAT_W-1:0]                 beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
    // The write line and the read line are kept in separate registers.
    // This lets line_o keep the last read result while a write is in flight.
    logic [BEATS-1:0][BURST_WIDTH-1:0] wr_line_q, wr_line_d;
    logic [BEATS-1:0][BURST_WIDTH-1:0] rd_line_q, rd_line_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            addr_q    <= '0;
            wr_line_q <= '0;
            rd_line_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            wr_line_q <= wr_line_d;
            rd_line_q <= rd_line_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        wr_line_d = wr_line_q;
        rd_line_d = rd_line_q;
        unique case (state_q)
            StIdle: begin
                // A write wins when both requests are high.
                if (bus.write_i) begin
                    state_d   = StWrite;
                    beat_d    = '0;
                    wr_line_d = bus.line_i;
                    addr_d    = {bus.address_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                end else if (bus.read_i) begin
                    state_d = StRead;
                    beat_d  = '0;
                    addr_d  = {bus.address_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                end
            end
            StRead: begin
                if (bus.resp_i) begin
                    rd_line_d[beat_q] = bus.burst_i;
                    // On the last beat the counter holds instead of wrapping to 0.
                    if (beat_q == LAST_BEAT) begin
                        state_d = StDone;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            StWrite: begin
                if (bus.resp_i) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = StDone;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // All outputs are Moore outputs, decoded from the registered state.
    assign bus.read_o    = (state_q == StRead);
    assign bus.write_o   = (state_q == StWrite);
    assign bus.resp_o    = (state_q == StDone);
    assign bus.address_o = addr_q;
    assign bus.burst_o   = wr_line_q[beat_q];
    assign bus.line_o    = rd_line_q;

endmodule
